// File: rtl/booth_r4_mult.sv
// Radix-4 Booth signed multiplier with a fixed WIDTH/2-cycle iteration.
// Returns the low WIDTH product bits plus a signed-overflow flag.
module booth_r4_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int ITER = WIDTH / 2;
    localparam int CW   = $clog2(ITER + 1);
    localparam int PW   = 2 * WIDTH + 3;
    localparam int UW   = WIDTH + 2;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] mcand;
    logic [PW-1:0]   prod;
    logic [PW-1:0]   prod_nxt;
    logic [UW-1:0]   upper;
    logic [UW-1:0]   m1;
    logic [UW-1:0]   m2;
    logic [UW-1:0]   addend;
    logic [UW-1:0]   operand;
    logic [UW-1:0]   sum;
    logic [WIDTH+2:0] hi_bits;
    logic            op_add;
    logic            op_sub;
    logic            op_two;
    logic            start;
    logic            last;
    logic            exc_nxt;

    assign start = ctrl_MULT && (state != RUN);
    assign last  = (state == RUN) && (cnt == LAST);

    assign data_resultRDY = (state == DONE);
    assign busy           = (state == RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (ctrl_MULT) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = ctrl_MULT ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Booth triplet {b[i+1], b[i], b[i-1]} sits in the low three bits
    always_comb begin
        op_add = 1'b0;
        op_sub = 1'b0;
        op_two = 1'b0;
        unique case (prod[2:0])
            3'b001, 3'b010: op_add = 1'b1;
            3'b011: begin
                op_add = 1'b1;
                op_two = 1'b1;
            end
            3'b100: begin
                op_sub = 1'b1;
                op_two = 1'b1;
            end
            3'b101, 3'b110: op_sub = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        m1      = {{2{mcand[WIDTH-1]}}, mcand};
        m2      = {mcand[WIDTH-1], mcand, 1'b0};
        addend  = op_two ? m2 : m1;
        upper   = prod[PW-1:WIDTH+1];
        operand = '0;
        if (op_sub) begin
            operand = ~addend;
        end else if (op_add) begin
            operand = addend;
        end
        sum      = upper + operand + UW'(op_sub);
        prod_nxt = {{2{sum[UW-1]}}, sum, prod[WIDTH:2]};
        hi_bits  = prod_nxt[PW-1:WIDTH];
        // Fits in WIDTH bits only when all upper bits copy the result sign
        exc_nxt  = !((&hi_bits) || !(|hi_bits));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            mcand          <= '0;
            prod           <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            cnt   <= '0;
            mcand <= data_operandA;
            prod  <= {{UW{1'b0}}, data_operandB, 1'b0};
        end else if (state == RUN) begin
            cnt  <= cnt + CW'(1);
            prod <= prod_nxt;
            if (last) begin
                data_result    <= prod_nxt[WIDTH:1];
                data_exception <= exc_nxt;
            end
        end
    end

endmodule
